// File: rtl/rc_stat_reg_if.sv
// Software read port of the read-clear status register.
// The master issues rd_req; the slave answers with rd_valid/rd_data one cycle later.
interface rc_stat_reg_if #(
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, input rd_valid, input rd_data);
  modport slave  (input rd_req, output rd_valid, output rd_data);
endinterface

// File: rtl/rc_stat_reg.sv
// Read-clear status register: sticky hardware event bits, atomic clear-on-read,
// a saturating dropped-event counter and a masked, registered interrupt.
module rc_stat_reg #(
  parameter int                DATA_W        = 32,
  parameter logic [DATA_W-1:0] DEFAULT_VALUE = '0,
  parameter int                CNT_W         = 8
) (
  input  logic              clk_reg,
  input  logic              rst_reg,
  input  logic [DATA_W-1:0] hw_set,
  input  logic [DATA_W-1:0] irq_mask,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic              irq,
  rc_stat_reg_if.slave      rd_bus
);

  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic              irq_q, irq_d;
  logic              drop;

  always_comb begin
    status_d  = status_q | hw_set;
    ovf_cnt_d = ovf_cnt_q;
    // A read replaces the snapshot with only this cycle's events, so none are lost.
    if (rd_bus.rd_req) begin
      status_d = hw_set;
    end
    drop = (|(status_q & hw_set)) & ~rd_bus.rd_req;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (drop && (ovf_cnt_q != {CNT_W{1'b1}})) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
    irq_d = |(status_d & irq_mask);
  end

  always_ff @(posedge clk_reg) begin
    if (rst_reg) begin
      status_q   <= DEFAULT_VALUE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_cnt_q  <= '0;
      irq_q      <= |(DEFAULT_VALUE & irq_mask);
    end else begin
      status_q   <= status_d;
      rd_valid_q <= rd_bus.rd_req;
      if (rd_bus.rd_req) begin
        rd_data_q <= status_q;
      end
      ovf_cnt_q  <= ovf_cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign rd_bus.rd_valid = rd_valid_q;
  assign rd_bus.rd_data  = rd_data_q;
  assign ovf_cnt         = ovf_cnt_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_rc_stat_reg.sv
// Directed bench for rc_stat_reg: an 8-bit counter instance and a 2-bit one
// share the same stimulus so saturation can be seen quickly.
module tb_rc_stat_reg;

  logic       clk_reg = 1'b0;
  logic       rst_reg;
  logic [7:0] hw_set;
  logic [7:0] irq_mask;
  logic       ovf_clr;
  logic       rd_req;

  logic [7:0] ovf_cnt8;
  logic [1:0] ovf_cnt2;
  logic       irq8, irq2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_reg = ~clk_reg;

  rc_stat_reg_if #(.DATA_W(8)) bus8 ();
  rc_stat_reg_if #(.DATA_W(8)) bus2 ();

  assign bus8.rd_req = rd_req;
  assign bus2.rd_req = rd_req;

  rc_stat_reg #(.DATA_W(8), .DEFAULT_VALUE(8'h81), .CNT_W(8)) u_dut8 (
    .clk_reg  (clk_reg),
    .rst_reg  (rst_reg),
    .hw_set   (hw_set),
    .irq_mask (irq_mask),
    .ovf_clr  (ovf_clr),
    .ovf_cnt  (ovf_cnt8),
    .irq      (irq8),
    .rd_bus   (bus8.slave)
  );

  rc_stat_reg #(.DATA_W(8), .DEFAULT_VALUE(8'h81), .CNT_W(2)) u_dut2 (
    .clk_reg  (clk_reg),
    .rst_reg  (rst_reg),
    .hw_set   (hw_set),
    .irq_mask (irq_mask),
    .ovf_clr  (ovf_clr),
    .ovf_cnt  (ovf_cnt2),
    .irq      (irq2),
    .rd_bus   (bus2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_reg);
    #1;
  endtask

  initial begin
    rst_reg  = 1'b1;
    hw_set   = 8'h00;
    irq_mask = 8'h01;
    ovf_clr  = 1'b0;
    rd_req   = 1'b0;

    tick();
    chk("rst_valid", 32'(bus8.rd_valid), 32'h0);
    chk("rst_data",  32'(bus8.rd_data),  32'h00);
    chk("rst_ovf",   32'(ovf_cnt8),      32'h0);
    chk("rst_irq",   32'(irq8),          32'h1);

    rst_reg = 1'b0;
    rd_req  = 1'b1;
    tick();
    chk("rd_default_valid", 32'(bus8.rd_valid), 32'h1);
    chk("rd_default_data",  32'(bus8.rd_data),  32'h81);
    chk("irq_after_clear",  32'(irq8),          32'h0);
    rd_req = 1'b0;

    // Events at separate cycles accumulate into one read.
    hw_set = 8'h04; tick();
    hw_set = 8'h00; tick();
    hw_set = 8'h10; tick();
    hw_set = 8'h00; tick();
    chk("idle_valid", 32'(bus8.rd_valid), 32'h0);
    rd_req = 1'b1;  tick();
    chk("acc_valid", 32'(bus8.rd_valid), 32'h1);
    chk("acc_data",  32'(bus8.rd_data),  32'h14);
    tick();
    chk("b2b_valid", 32'(bus8.rd_valid), 32'h1);
    chk("b2b_data",  32'(bus8.rd_data),  32'h00);
    rd_req = 1'b0;  tick();
    chk("hold_valid", 32'(bus8.rd_valid), 32'h0);
    chk("hold_data",  32'(bus8.rd_data),  32'h00);

    // Event arriving with a read is kept for the next read, not counted as drop.
    hw_set = 8'h02; tick();
    rd_req = 1'b1;  tick();
    chk("same_rd_data", 32'(bus8.rd_data), 32'h02);
    hw_set = 8'h00; tick();
    chk("kept_rd_data", 32'(bus8.rd_data), 32'h02);
    chk("same_ovf",     32'(ovf_cnt8),     32'h0);
    rd_req = 1'b0;

    // Repeated set without read: two drops.
    hw_set = 8'h01;
    tick(); tick(); tick();
    chk("drop_ovf2", 32'(ovf_cnt8), 32'h2);
    chk("drop_irq",  32'(irq8),     32'h1);
    ovf_clr = 1'b1; tick();
    chk("clr_wins8", 32'(ovf_cnt8), 32'h0);
    chk("clr_wins2", 32'(ovf_cnt2), 32'h0);
    ovf_clr = 1'b0;

    // Saturation of the narrow counter over five drop cycles.
    for (int i = 0; i < 3; i++) tick();
    chk("sat_at3", 32'(ovf_cnt2), 32'h3);
    tick(); tick();
    chk("sat_hold", 32'(ovf_cnt2), 32'h3);
    chk("wide_5",   32'(ovf_cnt8), 32'h5);
    ovf_clr = 1'b1; tick();
    chk("sat_clr", 32'(ovf_cnt2), 32'h0);
    ovf_clr = 1'b0;
    hw_set  = 8'h00;

    rd_req = 1'b1; tick();
    chk("clear01_data", 32'(bus8.rd_data), 32'h01);
    chk("ovf_not_rd",   32'(ovf_cnt8),     32'h0);
    rd_req = 1'b0;

    // Interrupt masking and clear-on-read.
    irq_mask = 8'h08;
    hw_set   = 8'h08; tick();
    chk("irq_set", 32'(irq8), 32'h1);
    hw_set = 8'h00; rd_req = 1'b1; tick();
    chk("irq_rd_data", 32'(bus8.rd_data), 32'h08);
    chk("irq_cleared", 32'(irq8),         32'h0);
    rd_req = 1'b0;
    hw_set = 8'h08;  tick();
    hw_set = 8'h00;
    irq_mask = 8'h00; tick();
    chk("mask_off", 32'(irq8), 32'h0);
    irq_mask = 8'h08; tick();
    chk("mask_on", 32'(irq8), 32'h1);
    rd_req = 1'b1; hw_set = 8'h08; tick();
    chk("irq_reset_bit", 32'(irq8), 32'h1);
    hw_set = 8'h00;

    // Reset together with a read drops the response.
    rst_reg = 1'b1; tick();
    chk("rstrd_valid", 32'(bus8.rd_valid), 32'h0);
    chk("rstrd_data",  32'(bus8.rd_data),  32'h00);
    chk("rstrd_irq",   32'(irq8),          32'h0);
    rst_reg = 1'b0; irq_mask = 8'h01; tick();
    chk("post_rst_data", 32'(bus8.rd_data), 32'h81);
    chk("post_rst_dut2", 32'(bus2.rd_data), 32'h81);
    rd_req = 1'b0; tick();
    chk("post_rst_idle", 32'(bus8.rd_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
